mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-master memory controller between the CPU-side request interface and the memory array blocks. Accepts one request at a time over a valid/ready handshake and decodes the 8-bit address into ROM (0–127), RAM (128–223) or unmapped (224–255). Drives the RAM's `we`/`address`/`data_in` and captures its registered read data (and the ROM's). Returns one response per request over a valid/ready handshake.

## Interface
- `ROM_TOP`, default 127: highest ROM address.
- `RAM_BASE`, default 128: lowest RAM address.
- `RAM_TOP`, default 223: highest RAM address; anything above is unmapped.
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 8: byte address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out 8: read data; 8'h00 for writes and errors.
- `rsp_err` out 1: access error (see Configuration).
- `ram_we` out 1: RAM write strobe.
- `ram_address` out 8: RAM/ROM address.
- `ram_data_in` out 8: RAM write data.
- `ram_data_out` in 8: RAM registered read data.
- `rom_data_out` in 8: ROM registered read data, same one-edge latency as RAM.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`/`req_addr`/`req_wdata` and the decoded region, then go to ACCESS.
- ACCESS:
  - `ram_address` = latched address.
  - `ram_data_in` = latched wdata.
  - `ram_we` = 1 only for a write to the RAM region.
  - Next state:
    - RAM or ROM read → CAPTURE.
    - RAM write → RESP.
    - ROM write or unmapped access → RESP with error, no strobe.
- CAPTURE:
  - `ram_address` held; `ram_we`=0.
  - Latch `ram_data_out` (RAM region) or `rom_data_out` (ROM region) into `rsp_rdata`.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_rdata`/`rsp_err` held stable.
  - On `rsp_ready`, go to IDLE.
  - `req_ready` stays 0 until IDLE, so there is no accept in the same cycle as a response retire.
- Outputs outside ACCESS/CAPTURE:
  - `ram_we`=0 always.
  - `ram_address` holds its last value, so the RAM never sees a spurious write.
- Region decode (unsigned 8-bit compares):
  - ROM when addr ≤ ROM_TOP.
  - RAM when RAM_BASE ≤ addr ≤ RAM_TOP.
  - Else unmapped.
  - Boundary addresses 127, 128, 223, 224 decode exactly per these bounds.

## Timing
- Accept at edge E0.
- ACCESS is the cycle E0→E1; the RAM acts at E1.
- Read: data latched at E2; `rsp_valid` high from E2.
- Write or error: `rsp_valid` high from E1.
- Throughput: one request per 3 cycles (write) or 4 cycles (read), including the IDLE accept cycle, assuming `rsp_ready`=1.
- Reset values:
  - State = IDLE; `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=8'h00, `rsp_err`=0.
  - `ram_we`=0, `ram_address`=8'h00, `ram_data_in`=8'h00.
- Reset mid-transaction aborts the request: `ram_we` drops asynchronously and no response is issued.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- `MEM_CTRL_ERR_EN` defined: ROM writes and unmapped accesses return `rsp_err`=1 and `rsp_rdata`=8'h00.
- Not defined: `rsp_err` is tied to 0; the same accesses complete silently with `rsp_rdata`=8'h00 and identical latency.

## Structure
- Package `mem_map_pkg`:
  - Default address bounds.
  - Region enum (ROM, RAM, UNMAPPED).
  - FSM state enum.
- Sub-module `mem_addr_decode`: combinational address → region, parameterised by the bounds.
- FSM and datapath registers live in `mem_ctrl`.

## Test plan
- After reset: `req_ready`=1, `rsp_valid`=0, `ram_we`=0, `ram_address`=8'h00.
- Write 8'hA5 to 8'd128, then read 8'd128:
  - Write: `ram_we` pulses exactly one cycle; `rsp_valid` one cycle after accept.
  - Read: `rsp_rdata`=8'hA5 two cycles after accept.
- Writes to 8'd223 (8'h3C) and 8'd224 (8'hFF), then reads of both:
  - 223 reads 8'h3C.
  - 224: no `ram_we`; with `MEM_CTRL_ERR_EN`, `rsp_err`=1 and `rsp_rdata`=8'h00.
- Write to 8'd5 (ROM): no `ram_we`; `rsp_err`=1 with macro, 0 without.
- Hold `rsp_ready`=0 for 5 cycles on a read response: `rsp_valid`/`rsp_rdata` stable and `req_ready`=0 throughout; retire returns to IDLE.
- Assert `reset` during ACCESS of a RAM write: `ram_we` drops immediately, no response, state IDLE.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared address map bounds, region and FSM state types for the memory controller.
package mem_map_pkg;

   localparam logic [7:0] ROM_TOP_DEF  = 8'd127;
   localparam logic [7:0] RAM_BASE_DEF = 8'd128;
   localparam logic [7:0] RAM_TOP_DEF  = 8'd223;

   typedef enum logic [1:0] {
      REGION_ROM,
      REGION_RAM,
      REGION_UNMAPPED
   } region_e;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      CAPTURE,
      RESP
   } state_e;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational byte address to memory region decode.
module mem_addr_decode
   import mem_map_pkg::*;
#(
   parameter logic [7:0] ROM_TOP  = ROM_TOP_DEF,
   parameter logic [7:0] RAM_BASE = RAM_BASE_DEF,
   parameter logic [7:0] RAM_TOP  = RAM_TOP_DEF
) (
   input  logic [7:0] addr_i,
   output region_e    region_o
);

   always_comb begin
      region_o = REGION_UNMAPPED;
      if (addr_i <= ROM_TOP) begin
         region_o = REGION_ROM;
      end else if ((addr_i >= RAM_BASE) && (addr_i <= RAM_TOP)) begin
         region_o = REGION_RAM;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Single-request memory controller: CPU valid/ready request in, ROM/RAM access, one response out.
// Define MEM_CTRL_ERR_EN to report ROM writes and unmapped accesses on rsp_err.
module mem_ctrl
   import mem_map_pkg::*;
#(
   parameter logic [7:0] ROM_TOP  = ROM_TOP_DEF,
   parameter logic [7:0] RAM_BASE = RAM_BASE_DEF,
   parameter logic [7:0] RAM_TOP  = RAM_TOP_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       ram_we,
   output logic [7:0] ram_address,
   output logic [7:0] ram_data_in,
   input  logic [7:0] ram_data_out,
   input  logic [7:0] rom_data_out
);

   state_e     state_q,  state_d;
   logic       we_q,     we_d;
   logic [7:0] addr_q,   addr_d;
   logic [7:0] wdata_q,  wdata_d;
   region_e    region_q, region_d;
   logic [7:0] rdata_q,  rdata_d;
   region_e    req_region;
`ifdef MEM_CTRL_ERR_EN
   logic       err_q,    err_d;
`endif

   mem_addr_decode #(
      .ROM_TOP  (ROM_TOP),
      .RAM_BASE (RAM_BASE),
      .RAM_TOP  (RAM_TOP)
   ) u_decode (
      .addr_i   (req_addr),
      .region_o (req_region)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         region_q <= REGION_ROM;
         rdata_q  <= '0;
`ifdef MEM_CTRL_ERR_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         region_q <= region_d;
         rdata_q  <= rdata_d;
`ifdef MEM_CTRL_ERR_EN
         err_q    <= err_d;
`endif
      end
   end

   // ram_we is decoded from state so an asynchronous reset drops it immediately.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      region_d  = region_q;
      rdata_d   = rdata_q;
`ifdef MEM_CTRL_ERR_EN
      err_d     = err_q;
`endif
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      ram_we    = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               region_d = req_region;
               rdata_d  = '0;
`ifdef MEM_CTRL_ERR_EN
               err_d    = 1'b0;
`endif
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (we_q && (region_q == REGION_RAM)) begin
               ram_we  = 1'b1;
               state_d = RESP;
            end else if (!we_q && (region_q != REGION_UNMAPPED)) begin
               state_d = CAPTURE;
            end else begin
`ifdef MEM_CTRL_ERR_EN
               err_d   = 1'b1;
`endif
               state_d = RESP;
            end
         end
         CAPTURE: begin
            rdata_d = (region_q == REGION_RAM) ? ram_data_out : rom_data_out;
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ram_address = addr_q;
   assign ram_data_in = wdata_q;
   assign rsp_rdata   = rdata_q;
`ifdef MEM_CTRL_ERR_EN
   assign rsp_err     = err_q;
`else
   assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with behavioural registered RAM and ROM models.
module tb_mem_ctrl;

`ifdef MEM_CTRL_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic       clk, reset;
   logic       req_valid, req_ready, req_we;
   logic [7:0] req_addr, req_wdata;
   logic       rsp_valid, rsp_ready, rsp_err;
   logic [7:0] rsp_rdata;
   logic       ram_we;
   logic [7:0] ram_address, ram_data_in, ram_data_out, rom_data_out;

   typedef struct packed {
      logic [7:0] rd;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] ram_mem [256];
   logic [7:0] exp_ram [256];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   mem_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .ram_we       (ram_we),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out),
      .rom_data_out (rom_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 8'h00;
         exp_ram[i] = 8'h00;
      end
   end

   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_address] <= ram_data_in;
      ram_data_out <= ram_mem[ram_address];
      rom_data_out <= ram_address ^ 8'h5A;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Entered and left at a negedge with the DUT idle.
   task automatic do_txn(input logic we, input logic [7:0] a, input logic [7:0] d,
                         input int unsigned hold);
      logic        is_rom, is_ram;
      exp_t        e, got;
      int unsigned exp_lat, exp_we, lat, wecnt;
      logic [7:0]  first;
      is_rom  = (a <= 8'd127);
      is_ram  = (a >= 8'd128) && (a <= 8'd223);
      e.rd    = 8'h00;
      e.err   = 1'b0;
      exp_we  = 0;
      exp_lat = 1;
      if (we) begin
         if (is_ram) begin
            exp_ram[a] = d;
            exp_we     = 1;
         end else begin
            e.err = ERR;
         end
      end else if (is_ram) begin
         e.rd    = exp_ram[a];
         exp_lat = 2;
      end else if (is_rom) begin
         e.rd    = a ^ 8'h5A;
         exp_lat = 2;
      end else begin
         e.err = ERR;
      end
      sb.push_back(e);

      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = ~a;
      req_wdata = ~d;
      lat   = 0;
      wecnt = 0;
      while (!rsp_valid && lat < 8) begin
         if (lat == 0) begin
            check("ram_address", ram_address, a);
            check("req_ready_busy", req_ready, 0);
         end
         if (ram_we) begin
            wecnt++;
            check("ram_data_in", ram_data_in, d);
         end
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check("rsp_latency", lat, exp_lat);
      check("ram_we_pulses", wecnt, exp_we);
      got = sb.pop_front();
      if (rsp_valid) begin
         check("rsp_rdata", rsp_rdata, got.rd);
         check("rsp_err", rsp_err, got.err);
         check("ram_we_in_resp", ram_we, 0);
         first = rsp_rdata;
         for (int unsigned k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_rdata", rsp_rdata, first);
            check("hold_req_ready", req_ready, 0);
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         rsp_ready = 1'b0;
         check("retire_rsp_valid", rsp_valid, 0);
         check("retire_req_ready", req_ready, 1);
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 8'h00;
      req_wdata = 8'h00;
      rsp_ready = 1'b0;
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_address", ram_address, 8'h00);
      check("rst_ram_data_in", ram_data_in, 8'h00);
      check("rst_rsp_rdata", rsp_rdata, 8'h00);
      check("rst_rsp_err", rsp_err, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      do_txn(1'b1, 8'd128, 8'hA5, 0);
      do_txn(1'b0, 8'd128, 8'h00, 0);
      do_txn(1'b1, 8'd223, 8'h3C, 0);
      do_txn(1'b1, 8'd224, 8'hFF, 0);
      do_txn(1'b0, 8'd223, 8'h00, 0);
      do_txn(1'b0, 8'd224, 8'h00, 0);
      do_txn(1'b1, 8'd5,   8'h99, 0);
      do_txn(1'b0, 8'd5,   8'h00, 0);
      do_txn(1'b0, 8'd127, 8'h00, 0);
      do_txn(1'b0, 8'd128, 8'h00, 5);
      do_txn(1'b1, 8'd255, 8'h12, 2);

      // Reset while a RAM write sits in ACCESS: the strobe must drop at once.
      check("req_ready_pre_abort", req_ready, 1);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 8'd130;
      req_wdata = 8'h77;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_ram_we_before", ram_we, 1);
      #1 reset = 1'b1;
      #1;
      check("abort_ram_we_after", ram_we, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_req_ready", req_ready, 1);
      check("abort_ram_address", ram_address, 8'h00);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
      do_txn(1'b0, 8'd130, 8'h00, 0);

      for (int i = 0; i < 12; i++) begin
         logic        w;
         logic [7:0]  a, d;
         w = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         do_txn(w, a, d, $urandom_range(0, 2));
      end

      check("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
